div_clk_monitor: RTL and testbench

Checker stage that sits directly downstream of the divide-by-5 clock generator and consumes its divided output `f`. It measures the period and high time of `f` in `clk` cycles and reports each measurement. It declares lock after a run of in-spec periods and raises sticky errors on period, duty or missing-edge faults. It gives the bench and the system a self-check of the divider without probing internal state.

---
 rtl/div_clk_monitor_if.sv | 40 ++++
 rtl/div_clk_monitor.sv | 154 +++++++++++++++
 tb/tb_div_clk_monitor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if
//   Bundles the control inputs and measurement/status outputs of the divided
//   clock monitor.
//   master : drives en, f_in and clr_err; observes the measurement and status signals.
//   slave  : the monitor itself.
//   Signals:
//     en         monitor enable
//     f_in       divided clock under test (asynchronous to clk)
//     clr_err    one-cycle pulse that clears the sticky error flags
//     period     last measured rise-to-rise interval, in clk cycles
//     high_time  sampled high cycles within that interval
//     meas_valid one-cycle pulse when period/high_time update
//     locked     a run of consecutive good measurements has been seen
//     err_period sticky flag: an off-nominal period was measured
//     err_duty   sticky flag: a high time outside the allowed range was measured
//     timeout    sticky flag: a rising edge of f_in did not arrive in time
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             f_in;
  logic             clr_err;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_duty;
  logic             timeout;

  modport master (
    output en, f_in, clr_err,
    input  period, high_time, meas_valid, locked, err_period, err_duty, timeout
  );

  modport slave (
    input  en, f_in, clr_err,
    output period, high_time, meas_valid, locked, err_period, err_duty, timeout
  );
endinterface

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Checks the output of the divide-by-5 clock generator. The monitor
//   synchronizes f_in into the clk domain and measures each rise-to-rise
//   period and the sampled high time within it. It reports every measurement
//   and declares lock after LOCK_COUNT consecutive good measurements. It also
//   keeps sticky period, duty and missing-edge (timeout) error flags.
//   Ports:
//     clk  clock; all state updates on the rising edge
//     rst  asynchronous, active-high reset
//     bus  div_clk_monitor_if slave: en, f_in and clr_err in; period,
//          high_time, meas_valid, locked, err_period, err_duty and timeout out
module div_clk_monitor #(
  parameter int EXP_PERIOD = 5,
  parameter int HIGH_MIN   = 2,
  parameter int HIGH_MAX   = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  div_clk_monitor_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam int               GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_SAT = GOOD_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  TMO_P    = CNT_W'(2 * EXP_PERIOD);
  localparam logic [CNT_W-1:0]  HI_LO    = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0]  HI_HI    = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  logic              f_m, f_s, f_d;
  logic [1:0]        state;
  logic [CNT_W-1:0]  per_cnt, hi_cnt;
  logic [GOOD_W-1:0] good_cnt, good_inc;
  logic [CNT_W-1:0]  period_q, high_q;
  logic              meas_q, locked_q, err_period_q, err_duty_q, timeout_q;

  logic rise, meas, tmo_hit, per_ok, hi_ok;
  logic set_ep, set_ed, set_to;

  assign rise     = f_s & ~f_d;
  assign per_ok   = (per_cnt == EXP_P);
  assign hi_ok    = (hi_cnt >= HI_LO) && (hi_cnt <= HI_HI);
  assign meas     = bus.en && (state == ST_MEASURE) && rise;
  // A rise in the same cycle as the limit closes a valid interval instead of timing out.
  assign tmo_hit  = bus.en && (state == ST_MEASURE) && !rise && (per_cnt == TMO_P);
  assign good_inc = (good_cnt == GOOD_SAT) ? good_cnt : good_cnt + 1'b1;

  assign set_ep = meas && !per_ok;
  assign set_ed = meas && !hi_ok;
  assign set_to = tmo_hit;

  // f_in is asynchronous to clk: two-flop synchronizer, then one delay stage
  // for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_m <= 1'b0;
      f_s <= 1'b0;
      f_d <= 1'b0;
    end else begin
      f_m <= bus.f_in;
      f_s <= f_m;
      f_d <= f_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      good_cnt <= '0;
      period_q <= '0;
      high_q   <= '0;
      meas_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      meas_q <= 1'b0;
      if (!bus.en) begin
        state    <= ST_IDLE;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        good_cnt <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            if (rise) begin
              state   <= ST_MEASURE;
              per_cnt <= ONE;
              hi_cnt  <= ONE;
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              period_q <= per_cnt;
              high_q   <= hi_cnt;
              meas_q   <= 1'b1;
              per_cnt  <= ONE;
              hi_cnt   <= ONE;
              if (per_ok && hi_ok) begin
                good_cnt <= good_inc;
                locked_q <= (good_inc == GOOD_SAT);
              end else begin
                good_cnt <= '0;
                locked_q <= 1'b0;
              end
            end else if (tmo_hit) begin
              // The partial interval is dropped; the next rise only re-arms.
              state    <= ST_ARM;
              per_cnt  <= '0;
              hi_cnt   <= '0;
              good_cnt <= '0;
              locked_q <= 1'b0;
            end else begin
              if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
              if (f_s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky flags: a new error in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_period_q <= 1'b0;
      err_duty_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      err_period_q <= set_ep | (err_period_q & ~bus.clr_err);
      err_duty_q   <= set_ed | (err_duty_q   & ~bus.clr_err);
      timeout_q    <= set_to | (timeout_q    & ~bus.clr_err);
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = meas_q;
  assign bus.locked     = locked_q;
  assign bus.err_period = err_period_q;
  assign bus.err_duty   = err_duty_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor
//   Self-checking bench for div_clk_monitor. Each driven rising edge of f_in
//   closes the interval of the previous pulse. At that point the expected
//   measurement and status are pushed to a scoreboard. They are popped and
//   compared whenever the DUT pulses meas_valid.
module tb_div_clk_monitor;

  localparam int LOCK = 4;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    bit          lk;
    bit          ep;
    bit          ed;
    bit          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  div_clk_monitor_if #(.CNT_W(8)) bus ();

  div_clk_monitor #(
    .EXP_PERIOD (5),
    .HIGH_MIN   (2),
    .HIGH_MAX   (3),
    .LOCK_COUNT (LOCK),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb[$];

  // reference model state
  bit          armed;
  int unsigned prev_h, prev_l, good;
  bit          m_lk, m_ep, m_ed, m_to;
  int unsigned last_per, last_hi;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_restart();
    armed = 1'b0;
    good  = 0;
    m_lk  = 1'b0;
  endtask

  // One f_in pulse: h cycles high then l cycles low.
  // clr_mode: 0 none, 1 clr_err with this rise's capture, 2 clr_err one cycle
  // later, 3 both.
  task automatic pulse(input int unsigned h, input int unsigned l, input int unsigned clr_mode);
    for (int unsigned i = 0; i < h + l; i++) begin
      @(negedge clk);
      bus.f_in    = (i < h);
      bus.clr_err = ((clr_mode == 1 || clr_mode == 3) && i == 2) ||
                    ((clr_mode == 2 || clr_mode == 3) && i == 3);
      if (i == 0) begin
        if (armed) begin
          exp_t        e;
          int unsigned p;
          p = prev_h + prev_l;
          if (clr_mode == 1 || clr_mode == 3) begin
            m_ep = 1'b0; m_ed = 1'b0; m_to = 1'b0;
          end
          if (p == 5 && prev_h >= 2 && prev_h <= 3) begin
            if (good < LOCK) good++;
            m_lk = (good >= LOCK);
          end else begin
            good = 0;
            m_lk = 1'b0;
            if (p != 5) m_ep = 1'b1;
            if (prev_h < 2 || prev_h > 3) m_ed = 1'b1;
          end
          e = '{per: p, hi: prev_h, lk: m_lk, ep: m_ep, ed: m_ed, to: m_to};
          sb.push_back(e);
          last_per = p;
          last_hi  = prev_h;
        end else begin
          armed = 1'b1;
        end
        prev_h = h;
        prev_l = l;
      end
    end
    if (clr_mode >= 2) begin
      m_ep = 1'b0; m_ed = 1'b0; m_to = 1'b0;
      check("clr_err_period", bus.err_period, 0);
      check("clr_err_duty",   bus.err_duty,   0);
      check("clr_timeout",    bus.timeout,    0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_period"},     bus.period,     0);
    check({tag, "_high_time"},  bus.high_time,  0);
    check({tag, "_meas_valid"}, bus.meas_valid, 0);
    check({tag, "_locked"},     bus.locked,     0);
    check({tag, "_err_period"}, bus.err_period, 0);
    check({tag, "_err_duty"},   bus.err_duty,   0);
    check({tag, "_timeout"},    bus.timeout,    0);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_meas_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("meas_period",     bus.period,     e.per);
        check("meas_high_time",  bus.high_time,  e.hi);
        check("meas_locked",     bus.locked,     e.lk);
        check("meas_err_period", bus.err_period, e.ep);
        check("meas_err_duty",   bus.err_duty,   e.ed);
        check("meas_timeout",    bus.timeout,    e.to);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.f_in = 1'b0;
    bus.clr_err = 1'b0;
    model_restart();
    m_ep = 0; m_ed = 0; m_to = 0;
    prev_h = 0; prev_l = 0; last_per = 0; last_hi = 0;

    #12;
    check_reset_vals("por");
    @(negedge clk) rst = 1'b0;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk);

    // reference divider pattern, lock on the 4th measurement
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) pulse(2, 3, 0);
      else            pulse(3, 2, 0);
    end

    // one stretched period, then relock
    pulse(2, 4, 0);
    repeat (5) pulse(2, 3, 0);

    // missing edges: timeout 10 cycles after the last captured rise
    pulse(2, 3, 0);
    repeat (8) @(negedge clk);
    check("timeout_early", bus.timeout, 0);
    @(negedge clk);
    check("timeout_set",    bus.timeout, 1);
    check("timeout_locked", bus.locked,  0);
    model_restart();
    m_to = 1'b1;
    repeat (6) pulse(2, 3, 0);

    // clear with a good capture, then a duty fault
    pulse(2, 3, 1);
    pulse(4, 1, 0);
    pulse(2, 3, 0);
    // duty fault captured with clr_err in the same cycle, clr_err alone next cycle
    pulse(4, 1, 0);
    pulse(2, 3, 3);

    // asynchronous reset in the middle of a period
    pulse(2, 3, 0);
    @(negedge clk) bus.f_in = 1'b1;
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.f_in = 1'b0;
    model_restart();
    m_ep = 0; m_ed = 0; m_to = 0;
    @(negedge clk);
    repeat (6) pulse(2, 3, 0);

    // period fault, then disable for 3 cycles
    pulse(2, 4, 0);
    pulse(2, 3, 0);
    @(negedge clk) bus.en = 1'b0;
    model_restart();
    repeat (3) @(negedge clk);
    check("en_low_locked",     bus.locked,     0);
    check("en_low_err_period", bus.err_period, m_ep);
    check("en_low_err_duty",   bus.err_duty,   m_ed);
    check("en_low_timeout",    bus.timeout,    m_to);
    check("en_low_period",     bus.period,     last_per);
    check("en_low_high_time",  bus.high_time,  last_hi);
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk);
    repeat (6) pulse(2, 3, 0);

    repeat (4) @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
